// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// - funct3 encodings for loads and stores
// - FSM state encoding (request phase / load response outstanding)
// - access-size decode helper used by the alignment/format logic
package mem_stage_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StResp = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } acc_size_e;

    // Unlisted funct3 codes fall back to a full-word access.
    function automatic acc_size_e acc_size(input logic is_load, input logic [2:0] funct3);
        acc_size_e size;
        size = SizeWord;
        if (is_load) begin
            case (funct3)
                Funct3Lb, Funct3Lbu: size = SizeByte;
                Funct3Lh, Funct3Lhu: size = SizeHalf;
                default:             size = SizeWord;
            endcase
        end else begin
            case (funct3)
                Funct3Sb: size = SizeByte;
                Funct3Sh: size = SizeHalf;
                Funct3Sw: size = SizeWord;
                default:  size = SizeWord;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus.
// master (pipeline): drives req, we, addr (word aligned), be, wdata; receives gnt, rvalid, rdata.
// slave (memory):    the reverse direction.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Purely combinational load/store alignment and formatting.
// Inputs : is_load_i, funct3_i (size/sign), off_i (addr[1:0]), store_data_i, rdata_i
// Outputs: misalign_o (access not naturally aligned), be_o / wdata_o (lane-aligned store),
//          load_data_o (selected lane, sign- or zero-extended)
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic        is_load_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    acc_size_e   size;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        size       = acc_size(is_load_i, funct3_i);
        misalign_o = 1'b0;
        be_o       = 4'b1111;
        wdata_o    = store_data_i;
        unique case (size)
            SizeByte: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SizeHalf: begin
                misalign_o = off_i[0];
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{store_data_i[15:0]}};
            end
            default: begin
                misalign_o = |off_i;
            end
        endcase
    end

    // Halfword lane only needs off[1]; off[0]=1 is rejected as misaligned.
    always_comb begin
        lane_b = rdata_i[{off_i, 3'b000} +: 8];
        lane_h = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            Funct3Lb:  load_data_o = {{24{lane_b[7]}}, lane_b};
            Funct3Lh:  load_data_o = {{16{lane_h[15]}}, lane_h};
            Funct3Lbu: load_data_o = {24'h0, lane_b};
            Funct3Lhu: load_data_o = {16'h0, lane_h};
            Funct3Lw:  load_data_o = rdata_i;
            default:   load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data-memory bus, stalls the
// front of the pipeline while a transaction is outstanding, and owns the MEM/WB register.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   ex_mem_*_i             EX/MEM register contents (held stable while mem_hold_o=1)
//   dmem                   data-memory bus (master side)
//   mem_hold_o             stall IF/ID/EX and the EX/MEM register
//   misalign_o             one-cycle pulse when a misaligned access was dropped
//   mem_wb_reg_w_*_o       MEM/WB register (to forwarding unit and register file)
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_mem_reg_w_addr_i,
    input  logic        ex_mem_reg_w_ena_i,
    input  logic [31:0] ex_mem_reg_w_data_i,
    input  logic        ex_mem_mem_r_ena_i,
    input  logic        ex_mem_mem_w_ena_i,
    input  logic [2:0]  ex_mem_funct3_i,
    input  logic [31:0] ex_mem_store_data_i,
    mem_stage_if.master dmem,
    output logic        mem_hold_o,
    output logic        misalign_o,
    output logic [4:0]  mem_wb_reg_w_addr_o,
    output logic        mem_wb_reg_w_ena_o,
    output logic [31:0] mem_wb_reg_w_data_o
);

    mem_state_e  state_q, state_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_ena_q, wb_ena_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;

    logic        mem_op;
    logic        misalign;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        req_c;
    logic        hold_c;

    assign mem_op = ex_mem_mem_r_ena_i | ex_mem_mem_w_ena_i;

    mem_stage_lsu_align u_align (
        .is_load_i    (ex_mem_mem_r_ena_i),
        .funct3_i     (ex_mem_funct3_i),
        .off_i        (ex_mem_reg_w_data_i[1:0]),
        .store_data_i (ex_mem_store_data_i),
        .rdata_i      (dmem.rdata),
        .misalign_o   (misalign),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        state_d    = state_q;
        wb_addr_d  = wb_addr_q;
        wb_ena_d   = wb_ena_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        req_c      = 1'b0;
        hold_c     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!mem_op) begin
                    wb_addr_d = ex_mem_reg_w_addr_i;
                    wb_ena_d  = ex_mem_reg_w_ena_i;
                    wb_data_d = ex_mem_reg_w_data_i;
                end else if (misalign) begin
                    // Dropped access: retire as a bubble and flag it.
                    wb_addr_d  = ex_mem_reg_w_addr_i;
                    wb_ena_d   = 1'b0;
                    wb_data_d  = ex_mem_reg_w_data_i;
                    misalign_d = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (!dmem.gnt) begin
                        hold_c = 1'b1;
                    end else if (ex_mem_mem_w_ena_i) begin
                        wb_addr_d = ex_mem_reg_w_addr_i;
                        wb_ena_d  = 1'b0;
                        wb_data_d = ex_mem_reg_w_data_i;
                    end else begin
                        hold_c  = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (dmem.rvalid) begin
                    wb_addr_d = ex_mem_reg_w_addr_i;
                    wb_ena_d  = ex_mem_reg_w_ena_i;
                    wb_data_d = load_data;
                    state_d   = StIdle;
                end else begin
                    hold_c = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wb_addr_q  <= 5'd0;
            wb_ena_q   <= 1'b0;
            wb_data_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_addr_q  <= wb_addr_d;
            wb_ena_q   <= wb_ena_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    // Reset gates req/hold directly so they drop without waiting for EX/MEM to clear.
    assign dmem.req   = req_c & ~rst;
    assign dmem.we    = ex_mem_mem_w_ena_i;
    assign dmem.addr  = {ex_mem_reg_w_data_i[31:2], 2'b00};
    assign dmem.be    = be;
    assign dmem.wdata = wdata;

    assign mem_hold_o          = hold_c & ~rst;
    assign misalign_o          = misalign_q;
    assign mem_wb_reg_w_addr_o = wb_addr_q;
    assign mem_wb_reg_w_ena_o  = wb_ena_q;
    assign mem_wb_reg_w_data_o = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  ex_addr;
    logic        ex_wen;
    logic [31:0] ex_data;
    logic        ex_ld;
    logic        ex_st;
    logic [2:0]  ex_f3;
    logic [31:0] ex_sd;
    logic        hold;
    logic        mis;
    logic [4:0]  wb_addr;
    logic        wb_ena;
    logic [31:0] wb_data;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_mem_reg_w_addr_i (ex_addr),
        .ex_mem_reg_w_ena_i  (ex_wen),
        .ex_mem_reg_w_data_i (ex_data),
        .ex_mem_mem_r_ena_i  (ex_ld),
        .ex_mem_mem_w_ena_i  (ex_st),
        .ex_mem_funct3_i     (ex_f3),
        .ex_mem_store_data_i (ex_sd),
        .dmem                (dmem),
        .mem_hold_o          (hold),
        .misalign_o          (mis),
        .mem_wb_reg_w_addr_o (wb_addr),
        .mem_wb_reg_w_ena_o  (wb_ena),
        .mem_wb_reg_w_data_o (wb_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] alu;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] sd;
    } op_t;

    typedef struct {
        logic [4:0]  addr;
        logic        ena;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    bit   mon_en = 1'b0;

    logic [7:0]  mref [int unsigned];  // reference model: byte-addressed memory
    logic [31:0] smem [int unsigned];  // memory device behind the bus: word-addressed

    int gnt_cfg = -1;  // -1: random grant delay
    int rv_cfg  = -1;  // -1: random response delay
    int gnt_cnt = -1;
    int rv_cnt  = 0;
    logic [31:0] rv_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'((a * 29 + (a >> 3)) ^ 32'h5a);
    endfunction

    function automatic logic [7:0] ref_rd(input int unsigned a);
        if (mref.exists(a)) return mref[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] dev_rd(input int unsigned w);
        if (smem.exists(w)) return smem[w];
        return {init_byte(w * 4 + 3), init_byte(w * 4 + 2), init_byte(w * 4 + 1), init_byte(w * 4)};
    endfunction

    function automatic int nbytes(input logic ld, input logic [2:0] f3);
        if (ld) begin
            if (f3 == 3'd0 || f3 == 3'd4) return 1;
            if (f3 == 3'd1 || f3 == 3'd5) return 2;
            return 4;
        end
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input op_t op);
        return (op.ld || op.st) && ((op.alu % nbytes(op.ld, op.f3)) != 0);
    endfunction

    function automatic op_t mk_op(input logic [4:0] rd, input logic wen, input logic [31:0] alu,
                                  input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] sd);
        op_t o;
        o.rd = rd; o.wen = wen; o.alu = alu; o.ld = ld; o.st = st; o.f3 = f3; o.sd = sd;
        return o;
    endfunction

    task automatic preload(input int unsigned a, input logic [31:0] w);
        smem[a >> 2] = w;
        for (int i = 0; i < 4; i++) mref[a + i] = w[8 * i +: 8];
    endtask

    // Architectural result of one instruction; stores update the reference memory.
    task automatic model_op(input op_t op, output exp_t e);
        int unsigned a;
        int          n;
        logic [31:0] v;
        a = op.alu;
        n = nbytes(op.ld, op.f3);
        e.addr = op.rd;
        e.ena  = op.wen;
        e.data = op.alu;
        e.mis  = is_mis(op);
        if (e.mis) begin
            e.ena = 1'b0;
        end else if (op.st) begin
            e.ena = 1'b0;
            for (int i = 0; i < n; i++) mref[a + i] = op.sd[8 * i +: 8];
        end else if (op.ld) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8 * i +: 8] = ref_rd(a + i);
            if ((op.f3 == 3'd0 || op.f3 == 3'd1) && n < 4 && v[8 * n - 1])
                for (int i = n * 8; i < 32; i++) v[i] = 1'b1;
            e.data = v;
        end
    endtask

    task automatic drive(input op_t op);
        ex_addr = op.rd; ex_wen = op.wen; ex_data = op.alu;
        ex_ld = op.ld; ex_st = op.st; ex_f3 = op.f3; ex_sd = op.sd;
    endtask

    // Present one instruction at posedge+1 and wait until the stage lets it retire.
    task automatic run_op(input op_t op, output int hold_n, output int req_n,
                          output logic [3:0] be0, output logic [31:0] wd0);
        exp_t e;
        bit   done;
        drive(op);
        model_op(op, e);
        sbq.push_back(e);
        hold_n = 0; req_n = 0; be0 = '0; wd0 = '0; done = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            @(negedge clk);
            if (dmem.req === 1'b1) begin
                if (req_n == 0) begin
                    be0 = dmem.be;
                    wd0 = dmem.wdata;
                end
                req_n++;
            end
            if (hold === 1'b0) done = 1'b1;
            else hold_n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got hold stuck expected release within 32 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Memory device: grants after a delay, answers loads a few cycles after grant,
    // and sometimes emits a stray rvalid when nothing is outstanding.
    initial begin
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            dmem.rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dmem.rvalid = 1'b1;
                    dmem.rdata  = rv_data;
                end
            end else if ($urandom_range(0, 4) == 0) begin
                dmem.rvalid = 1'b1;
                dmem.rdata  = $urandom;
            end
            if (dmem.req === 1'b1) begin
                if (gnt_cnt < 0) gnt_cnt = (gnt_cfg >= 0) ? gnt_cfg : int'($urandom_range(0, 2));
                if (gnt_cnt == 0) begin
                    dmem.gnt = 1'b1;
                    gnt_cnt  = -1;
                    if (dmem.we) begin
                        logic [31:0] w;
                        w = dev_rd(dmem.addr >> 2);
                        for (int b = 0; b < 4; b++)
                            if (dmem.be[b]) w[8 * b +: 8] = dmem.wdata[8 * b +: 8];
                        smem[dmem.addr >> 2] = w;
                    end else begin
                        rv_cnt  = (rv_cfg >= 0) ? rv_cfg : int'($urandom_range(2, 4));
                        rv_data = dev_rd(dmem.addr >> 2);
                    end
                end else begin
                    dmem.gnt = 1'b0;
                    gnt_cnt--;
                end
            end else begin
                dmem.gnt = 1'b0;
                gnt_cnt  = -1;
            end
        end
    end

    // Monitor: each cycle the stage did not hold, MEM/WB captured one instruction.
    initial begin : monitor
        exp_t e;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got capture expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("wb_addr", 32'(wb_addr), 32'(e.addr));
                    chk("wb_ena", 32'(wb_ena), 32'(e.ena));
                    chk("wb_data", wb_data, e.data);
                    chk("misalign", 32'(mis), 32'(e.mis));
                end
            end
            pend = mon_en && (hold === 1'b0);
        end
    end

    initial begin
        op_t         op;
        op_t         bubble;
        int          h;
        int          r;
        logic [3:0]  be;
        logic [31:0] wd;
        int          kind;
        logic [31:0] a;

        bubble = mk_op(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(bubble);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_ena", 32'(wb_ena), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(mis), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        run_op(mk_op(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 3'd0, 32'd0), h, r, be, wd);
        chk("alu_req", r, 0);
        chk("alu_hold", h, 0);

        preload(32'h1000, 32'h80FF_FFFF);
        gnt_cfg = 0;
        rv_cfg  = 2;
        run_op(mk_op(5'd7, 1'b1, 32'h1003, 1'b1, 1'b0, 3'b000, 32'd0), h, r, be, wd);
        chk("lb_hold", h, 2);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        run_op(mk_op(5'd8, 1'b1, 32'h1003, 1'b1, 1'b0, 3'b100, 32'd0), h, r, be, wd);
        chk("lbu_data", wb_data, 32'h0000_0080);

        gnt_cfg = 2;
        run_op(mk_op(5'd9, 1'b1, 32'h2002, 1'b0, 1'b1, 3'b001, 32'h0000_ABCD), h, r, be, wd);
        chk("sh_req", r, 3);
        chk("sh_be", 32'(be), 32'h0000_000C);
        chk("sh_wdata", wd, 32'hABCD_ABCD);
        chk("sh_hold", h, 2);
        chk("sh_wb_ena", 32'(wb_ena), 32'd0);

        gnt_cfg = -1;
        rv_cfg  = -1;
        run_op(mk_op(5'd4, 1'b1, 32'h3001, 1'b1, 1'b0, 3'b010, 32'd0), h, r, be, wd);
        chk("lw_mis_req", r, 0);
        chk("lw_mis_hold", h, 0);
        chk("lw_mis_pulse", 32'(mis), 32'd1);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 1) == 1) a = a + 32'($urandom_range(0, 3));
            op = mk_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                       1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
            if (kind == 1) begin
                op.ld  = 1'b1;
                op.alu = a;
            end else if (kind == 2) begin
                op.st  = 1'b1;
                op.alu = a;
                op.f3  = 3'($urandom_range(0, 2));
            end
            run_op(op, h, r, be, wd);
            if (!(op.ld || op.st) || is_mis(op)) begin
                chk("quiet_req", r, 0);
                chk("quiet_hold", h, 0);
            end
        end

        mon_en = 1'b0;
        drive(bubble);
        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        // Reset while a load response is outstanding.
        gnt_cfg = 0;
        rv_cfg  = 4;
        @(posedge clk);
        #1;
        drive(mk_op(5'd3, 1'b1, 32'h104, 1'b1, 1'b0, 3'b010, 32'd0));
        @(negedge clk);
        chk("rstx_req_pre", 32'(dmem.req), 32'd1);
        @(negedge clk);
        chk("rstx_hold_pre", 32'(hold), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(bubble);
        #1;
        chk("rstx_req", 32'(dmem.req), 32'd0);
        chk("rstx_hold", 32'(hold), 32'd0);
        chk("rstx_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        gnt_cfg = -1;
        rv_cfg  = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rstx_post_data", wb_data, 32'd0);
            chk("rstx_post_hold", 32'(hold), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
